// File: rtl/addr_port_arbiter.sv
// Two-port write arbiter feeding a single register-file write port.
// Grants are combinational; the write path (sel/wr_*) and the drop counter
// are registered one cycle behind the grant. Ties are resolved round-robin
// with a bounded burst so one busy port cannot starve the other.
module addr_port_arbiter #(
  parameter int DW        = 32,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic [4:0]    addr0,
  input  logic [DW-1:0] data0,
  output logic          gnt0,
  input  logic          req1,
  input  logic [4:0]    addr1,
  input  logic [DW-1:0] data1,
  output logic          gnt1,
  output logic          sel,
  output logic          wr_en,
  output logic [4:0]    wr_addr,
  output logic [DW-1:0] wr_data,
  output logic [7:0]    drop_cnt
);

  localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_t;

  // Arbitration state: owner is the last granted port.
  logic       active;
  port_t      owner;
  logic [3:0] burst;

  // Decision for the current cycle.
  logic          grant_any;
  port_t         grant_port;
  logic [4:0]    xfer_addr;
  logic [DW-1:0] xfer_data;

  // Pick the port to grant this cycle; reset forces both grants low at once.
  always_comb begin
    // NOTE: every output of always_comb gets a default first so no path leaves it unassigned (no latch).
    grant_any  = 1'b0;
    grant_port = owner;
    if (!reset) begin
      unique case ({req1, req0})
        2'b01: begin
          grant_any  = 1'b1;
          grant_port = PORT0;
        end
        2'b10: begin
          grant_any  = 1'b1;
          grant_port = PORT1;
        end
        2'b11: begin
          grant_any  = 1'b1;
          // Owner keeps the port until its burst budget is spent.
          if (active && (burst < BURST_MAX)) grant_port = owner;
          else                               grant_port = port_t'(~owner);
        end
        default: ;
      endcase
    end
    gnt0      = grant_any && (grant_port == PORT0);
    gnt1      = grant_any && (grant_port == PORT1);
    xfer_addr = (grant_port == PORT1) ? addr1 : addr0;
    xfer_data = (grant_port == PORT1) ? data1 : data0;
  end

  // Track owner and burst length; an idle cycle ends the burst.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: nonblocking assignments in clocked blocks so every flop samples pre-edge values.
      active <= 1'b0;
      owner  <= PORT1;  // first tie after reset goes to port 0
      burst  <= 4'd0;
    end else if (grant_any) begin
      if ((grant_port == owner) && active) begin
        if (burst != BURST_MAX) burst <= burst + 4'd1;
      end else begin
        burst <= 4'd1;
      end
      owner  <= grant_port;
      active <= 1'b1;
    end else begin
      active <= 1'b0;
      burst  <= 4'd0;
    end
  end

  // Register the granted transfer; address 0 is consumed but only counted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel      <= 1'b0;
      wr_en    <= 1'b0;
      wr_addr  <= 5'd0;
      wr_data  <= '0;
      drop_cnt <= 8'd0;
    end else if (grant_any) begin
      sel     <= grant_port;
      wr_addr <= xfer_addr;
      wr_data <= xfer_data;
      wr_en   <= (xfer_addr != 5'd0);
      if ((xfer_addr == 5'd0) && (drop_cnt != 8'hff)) drop_cnt <= drop_cnt + 8'd1;
    end else begin
      wr_en <= 1'b0;
    end
  end

endmodule

// File: tb/tb_addr_port_arbiter.sv
// Directed bench for addr_port_arbiter: a MAX_BURST=4 instance for most
// scenarios and a MAX_BURST=1 instance for strict alternation.
// Inputs change on the falling edge; grants are checked 1 time unit later,
// registered outputs on the following falling edge.
module tb_addr_port_arbiter;

  localparam int DW = 32;

  logic          clk;
  logic          reset;
  logic          req0, req1;
  logic [4:0]    addr0, addr1;
  logic [DW-1:0] data0, data1;
  logic          gnt0, gnt1, sel, wr_en;
  logic [4:0]    wr_addr;
  logic [DW-1:0] wr_data;
  logic [7:0]    drop_cnt;

  logic          b_req0, b_req1;
  logic          b_gnt0, b_gnt1, b_sel, b_wr_en;
  logic [4:0]    b_wr_addr;
  logic [DW-1:0] b_wr_data;
  logic [7:0]    b_drop_cnt;

  int checks = 0;
  int fails  = 0;

  addr_port_arbiter #(.DW(DW), .MAX_BURST(4)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .addr0(addr0), .data0(data0), .gnt0(gnt0),
    .req1(req1), .addr1(addr1), .data1(data1), .gnt1(gnt1),
    .sel(sel), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .drop_cnt(drop_cnt)
  );

  addr_port_arbiter #(.DW(DW), .MAX_BURST(1)) dut_b1 (
    .clk(clk), .reset(reset),
    .req0(b_req0), .addr0(5'd1), .data0(32'h0000_00b0), .gnt0(b_gnt0),
    .req1(b_req1), .addr1(5'd2), .data1(32'h0000_00b1), .gnt1(b_gnt1),
    .sel(b_sel), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .drop_cnt(b_drop_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic idle_inputs();
    req0 = 1'b0; req1 = 1'b0;
    b_req0 = 1'b0; b_req1 = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    req0 = 1'b1; req1 = 1'b1; addr0 = 5'd3; addr1 = 5'd7;
    #1;
    checks++;
    if ({gnt0, gnt1} !== 2'b00) begin
      fails++; $display("FAIL reset_gnt: got %b expected 00", {gnt0, gnt1});
    end
    @(negedge clk);
    checks++;
    if ({wr_en, sel, wr_addr, wr_data, drop_cnt} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: wr_en=%b sel=%b wr_addr=%0d wr_data=%h drop_cnt=%0d expected all 0",
               wr_en, sel, wr_addr, wr_data, drop_cnt);
    end
    idle_inputs();
    reset = 1'b0;
  endtask

  task automatic test_round_robin();
    logic exp_port;
    do_reset();
    req0 = 1'b1; req1 = 1'b1;
    addr0 = 5'd3; addr1 = 5'd7;
    data0 = 32'h1111_0003; data1 = 32'h2222_0007;
    for (int i = 0; i < 16; i++) begin
      exp_port = ((i / 4) % 2) == 1;
      #1;
      checks++;
      if ({gnt0, gnt1} !== {~exp_port, exp_port}) begin
        fails++; $display("FAIL rr_gnt[%0d]: got %b expected %b", i, {gnt0, gnt1}, {~exp_port, exp_port});
      end
      @(negedge clk);
      checks++;
      if ({wr_en, sel, wr_addr, wr_data} !==
          {1'b1, exp_port, (exp_port ? 5'd7 : 5'd3), (exp_port ? 32'h2222_0007 : 32'h1111_0003)}) begin
        fails++;
        $display("FAIL rr_write[%0d]: wr_en=%b sel=%b wr_addr=%0d wr_data=%h expected sel=%b addr=%0d",
                 i, wr_en, sel, wr_addr, wr_data, exp_port, exp_port ? 7 : 3);
      end
    end
    idle_inputs();
    #1;
    checks++;
    if ({gnt0, gnt1} !== 2'b00) begin
      fails++; $display("FAIL rr_idle_gnt: got %b expected 00", {gnt0, gnt1});
    end
    @(negedge clk);
    checks++;
    if ({wr_en, sel, wr_addr} !== {1'b0, 1'b1, 5'd7}) begin
      fails++; $display("FAIL rr_hold: wr_en=%b sel=%b wr_addr=%0d expected 0 1 7", wr_en, sel, wr_addr);
    end
  endtask

  task automatic test_single_port();
    int en_count;
    en_count = 0;
    do_reset();
    req1 = 1'b1; addr1 = 5'd9; data1 = 32'hCAFE_0009;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++;
      if ({gnt0, gnt1} !== 2'b01) begin
        fails++; $display("FAIL single_gnt[%0d]: got %b expected 01", i, {gnt0, gnt1});
      end
      @(negedge clk);
      if (wr_en === 1'b1 && wr_addr === 5'd9 && sel === 1'b1) en_count++;
    end
    checks++;
    if (en_count !== 10) begin
      fails++; $display("FAIL single_wr_en_count: got %0d expected 10", en_count);
    end
    req0 = 1'b1; addr0 = 5'd5; data0 = 32'hBEEF_0005;
    #1;
    checks++;
    if ({gnt0, gnt1} !== 2'b10) begin
      fails++; $display("FAIL single_switch_gnt: got %b expected 10", {gnt0, gnt1});
    end
    @(negedge clk);
    checks++;
    if ({wr_en, sel, wr_addr, wr_data} !== {1'b1, 1'b0, 5'd5, 32'hBEEF_0005}) begin
      fails++; $display("FAIL single_switch_write: sel=%b wr_addr=%0d wr_data=%h expected 0 5 beef0005",
                        sel, wr_addr, wr_data);
    end
    idle_inputs();
  endtask

  task automatic test_drop();
    int en_seen;
    en_seen = 0;
    do_reset();
    req0 = 1'b1; addr0 = 5'd0; data0 = 32'h0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (gnt0 !== 1'b1) begin
        fails++; $display("FAIL drop_gnt[%0d]: got %b expected 1", i, gnt0);
      end
      @(negedge clk);
      if (wr_en !== 1'b0) en_seen++;
    end
    checks++;
    if (drop_cnt !== 8'd3) begin
      fails++; $display("FAIL drop_cnt3: got %0d expected 3", drop_cnt);
    end
    for (int i = 3; i < 300; i++) begin
      @(negedge clk);
      if (wr_en !== 1'b0) en_seen++;
    end
    checks++;
    if (en_seen !== 0) begin
      fails++; $display("FAIL drop_wr_en: wr_en high in %0d cycles, expected 0", en_seen);
    end
    checks++;
    if (drop_cnt !== 8'd255) begin
      fails++; $display("FAIL drop_saturate: got %0d expected 255", drop_cnt);
    end
    idle_inputs();
  endtask

  task automatic test_withdraw();
    do_reset();
    req0 = 1'b1; addr0 = 5'd4; data0 = 32'h4444_0004;
    @(negedge clk);
    // Port 1 asks with address 0 while port 0 holds the burst, then gives up.
    req1 = 1'b1; addr1 = 5'd0; data1 = 32'hDEAD_0000;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if ({gnt0, gnt1} !== 2'b10) begin
        fails++; $display("FAIL withdraw_gnt[%0d]: got %b expected 10", i, {gnt0, gnt1});
      end
      @(negedge clk);
    end
    req1 = 1'b0;
    @(negedge clk);
    req0 = 1'b0;
    @(negedge clk);
    checks++;
    if ({drop_cnt, sel, wr_addr, wr_data} !== {8'd0, 1'b0, 5'd4, 32'h4444_0004}) begin
      fails++; $display("FAIL withdraw_effect: drop_cnt=%0d sel=%b wr_addr=%0d wr_data=%h expected 0 0 4 44440004",
                        drop_cnt, sel, wr_addr, wr_data);
    end
  endtask

  task automatic test_idle_owner0();
    do_reset();
    req0 = 1'b1; addr0 = 5'd2;
    repeat (2) @(negedge clk);
    req0 = 1'b0;
    repeat (5) @(negedge clk);
    req0 = 1'b1; req1 = 1'b1; addr1 = 5'd8;
    #1;
    checks++;
    if ({gnt0, gnt1} !== 2'b01) begin
      fails++; $display("FAIL idle_owner0_gnt: got %b expected 01", {gnt0, gnt1});
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_async_reset();
    do_reset();
    req1 = 1'b1; addr1 = 5'd6; data1 = 32'h6666_0006;
    repeat (3) @(negedge clk);
    checks++;
    if ({wr_en, gnt1} !== 2'b11) begin
      fails++; $display("FAIL async_pre: wr_en/gnt1 got %b expected 11", {wr_en, gnt1});
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({gnt0, gnt1, wr_en, sel, wr_addr} !== '0) begin
      fails++; $display("FAIL async_reset: gnt=%b wr_en=%b sel=%b wr_addr=%0d expected all 0",
                        {gnt0, gnt1}, wr_en, sel, wr_addr);
    end
    @(negedge clk);
    reset = 1'b0;
    req0 = 1'b1; addr0 = 5'd2;
    #1;
    checks++;
    if ({gnt0, gnt1} !== 2'b10) begin
      fails++; $display("FAIL async_tie: got %b expected 10", {gnt0, gnt1});
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_max_burst1();
    logic exp_port;
    do_reset();
    b_req0 = 1'b1; b_req1 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      exp_port = (i % 2) == 1;
      #1;
      checks++;
      if ({b_gnt0, b_gnt1} !== {~exp_port, exp_port}) begin
        fails++; $display("FAIL burst1_gnt[%0d]: got %b expected %b", i, {b_gnt0, b_gnt1}, {~exp_port, exp_port});
      end
      @(negedge clk);
      checks++;
      if ({b_sel, b_wr_addr} !== {exp_port, (exp_port ? 5'd2 : 5'd1)}) begin
        fails++; $display("FAIL burst1_write[%0d]: sel=%b wr_addr=%0d", i, b_sel, b_wr_addr);
      end
    end
    idle_inputs();
  endtask

  initial begin
    reset = 1'b1;
    addr0 = 5'd0; addr1 = 5'd0; data0 = '0; data1 = '0;
    idle_inputs();
    test_reset();
    test_round_robin();
    test_single_port();
    test_drop();
    test_withdraw();
    test_idle_owner0();
    test_async_reset();
    test_max_burst1();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
